mem_access_unit: RTL and testbench

Load/store initiator that drives the word-wide synchronous RAM on behalf of the pipeline's memory stage. Accepts byte-addressed requests over a valid/ready handshake, issues RAM reads and writes, and returns responses over a valid/ready handshake. Loads are sign- or zero-extended; sub-word stores use read-modify-write; misaligned accesses are rejected with an error response.

---
 rtl/mem_access_unit.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Function : Load/store initiator for a word-wide synchronous RAM.
//            Optional counters enabled by defining MAU_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     mem_wEn,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut
`ifdef MAU_STATS_EN
    ,
    output logic [15:0]              cnt_load,
    output logic [15:0]              cnt_store,
    output logic [15:0]              cnt_err
`endif
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic                     r_we;
    logic [1:0]               r_size;
    logic                     r_unsigned;
    logic [1:0]               r_lane;
    logic [15:0]              r_wdata;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_mem_dataIn;
    logic [DATA_WIDTH-1:0]    r_resp_rdata;
    logic                     r_resp_err;

    logic                     w_accept;
    logic                     w_misaligned;
    logic [4:0]               w_bitofs;
    logic [DATA_WIDTH-1:0]    w_shifted;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic [DATA_WIDTH-1:0]    w_load;
    logic [DATA_WIDTH-1:0]    w_merged;

    assign w_misaligned = (req_size == 2'b11) ||
                          ((req_size == c_SIZE_HALF) && req_addr[0]) ||
                          ((req_size == c_SIZE_WORD) && (req_addr[1:0] != 2'b00));
    assign w_accept     = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // req_ready is gated by rst so nothing is accepted while reset is held
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wEn    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = ~rst;
                if (w_accept) begin
                    if (w_misaligned)                          w_next = RESP;
                    else if (req_we && req_size == c_SIZE_WORD) w_next = WR;
                    else                                        w_next = RD;
                end
            end
            RD:      w_next = RD_DATA;
            RD_DATA: w_next = r_we ? WR : RESP;
            WR: begin
                mem_wEn = 1'b1;
                w_next  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Little-endian lane extraction and sign/zero extension
    assign w_bitofs  = {r_lane, 3'b000};
    assign w_shifted = mem_dataOut >> w_bitofs;
    assign w_byte    = w_shifted[7:0];
    assign w_half    = r_lane[1] ? mem_dataOut[31:16] : mem_dataOut[15:0];

    always_comb begin
        w_load = mem_dataOut;
        case (r_size)
            c_SIZE_BYTE: w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            c_SIZE_HALF: w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default:     w_load = mem_dataOut;
        endcase
    end

    always_comb begin
        w_merged = mem_dataOut;
        case (r_size)
            c_SIZE_BYTE: w_merged[w_bitofs +: 8] = r_wdata[7:0];
            c_SIZE_HALF: begin
                if (r_lane[1]) w_merged[31:16] = r_wdata;
                else           w_merged[15:0]  = r_wdata;
            end
            default: w_merged = mem_dataOut;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_lane       <= 2'b00;
            r_wdata      <= '0;
            r_mem_addr   <= '0;
            r_mem_dataIn <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && w_accept) begin
                r_we         <= req_we;
                r_size       <= req_size;
                r_unsigned   <= req_unsigned;
                r_lane       <= req_addr[1:0];
                r_wdata      <= req_wdata[15:0];
                r_mem_addr   <= req_addr[ADDRESS_WIDTH+1:2];
                r_resp_rdata <= '0;
                r_resp_err   <= w_misaligned;
                if (req_we && req_size == c_SIZE_WORD && !w_misaligned)
                    r_mem_dataIn <= req_wdata;
            end
            if (r_state == RD_DATA) begin
                if (r_we) r_mem_dataIn <= w_merged;
                else      r_resp_rdata <= w_load;
            end
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_dataIn = r_mem_dataIn;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

`ifdef MAU_STATS_EN
    logic [15:0] r_cnt_load, r_cnt_store, r_cnt_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_load  <= '0;
            r_cnt_store <= '0;
            r_cnt_err   <= '0;
        end else if (resp_valid && resp_ready) begin
            if (r_resp_err) r_cnt_err   <= r_cnt_err + 16'd1;
            else if (r_we)  r_cnt_store <= r_cnt_store + 16'd1;
            else            r_cnt_load  <= r_cnt_load + 16'd1;
        end
    end

    assign cnt_load  = r_cnt_load;
    assign cnt_store = r_cnt_store;
    assign cnt_err   = r_cnt_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Function : Directed self-checking bench for mem_access_unit with a RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [13:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_wEn;
    logic [11:0] mem_addr;
    logic [31:0] mem_dataIn, mem_dataOut;

    int n_cmp = 0;
    int n_bad = 0;

    int          o_lat, o_wen_cnt, o_wen_cyc;
    logic [11:0] o_waddr;
    logic [31:0] o_wdata, o_rdata;
    logic        o_err, o_stable;

    logic [31:0] ram [0:4095];

    always #5 clk = ~clk;

    // Synchronous RAM, read-first, one-cycle read latency
    always @(posedge clk) begin
        if (mem_wEn) ram[mem_addr] <= mem_dataIn;
        mem_dataOut <= ram[mem_addr];
    end

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wEn(mem_wEn), .mem_addr(mem_addr),
        .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
    );

    // Drives one request and records latency, write pulses and the response
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [13:0] addr, input logic [31:0] wdata, input int hold);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        resp_ready = (hold == 0);
        o_lat = 0; o_wen_cnt = 0; o_wen_cyc = 0; o_waddr = '0;
        o_wdata = '0; o_rdata = '0; o_err = 1'b0; o_stable = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 12 && o_lat == 0; k++) begin
            if (mem_wEn) begin
                o_wen_cnt++; o_wen_cyc = k; o_waddr = mem_addr; o_wdata = mem_dataIn;
            end
            if (resp_valid) begin
                o_lat = k; o_rdata = resp_rdata; o_err = resp_err;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (o_lat != 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (!resp_valid || resp_rdata !== o_rdata || resp_err !== o_err ||
                    req_ready || mem_wEn)
                    o_stable = 1'b0;
            end
            resp_ready = 1'b1;
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
    endtask

    task automatic test_reset;
        n_cmp++; if ({req_ready, resp_valid, mem_wEn, resp_err} !== 4'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {req_ready, resp_valid, mem_wEn, resp_err}); end
        n_cmp++; if ({resp_rdata, mem_dataIn, mem_addr} !== 76'd0) begin
            n_bad++; $display("FAIL reset_data: rdata=%h dataIn=%h addr=%h want 0", resp_rdata, mem_dataIn, mem_addr); end
        rst = 1'b0; #1;
        n_cmp++; if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_word_store;
        issue(1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, 0);
        n_cmp++; if (o_lat !== 2) begin n_bad++; $display("FAIL sw_lat: got %0d want 2", o_lat); end
        n_cmp++; if (o_wen_cnt !== 1 || o_wen_cyc !== 1) begin
            n_bad++; $display("FAIL sw_wen: count %0d at %0d want 1 at 1", o_wen_cnt, o_wen_cyc); end
        n_cmp++; if (o_waddr !== 12'd4 || o_wdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL sw_wdata: addr %h data %h want 4 DEADBEEF", o_waddr, o_wdata); end
        n_cmp++; if (o_err !== 1'b0 || o_rdata !== 32'd0) begin
            n_bad++; $display("FAIL sw_resp: err %b rdata %h want 0 0", o_err, o_rdata); end
    endtask

    task automatic test_loads;
        issue(1'b0, 2'b00, 1'b0, 14'h013, 32'd0, 0);
        n_cmp++; if (o_rdata !== 32'hFFFFFFDE || o_lat !== 3) begin
            n_bad++; $display("FAIL lb_signed: %h lat %0d want FFFFFFDE lat 3", o_rdata, o_lat); end
        issue(1'b0, 2'b00, 1'b1, 14'h013, 32'd0, 0);
        n_cmp++; if (o_rdata !== 32'h000000DE || o_lat !== 3) begin
            n_bad++; $display("FAIL lb_unsigned: %h lat %0d want 000000DE lat 3", o_rdata, o_lat); end
        issue(1'b0, 2'b01, 1'b0, 14'h012, 32'd0, 0);
        n_cmp++; if (o_rdata !== 32'hFFFFDEAD || o_lat !== 3) begin
            n_bad++; $display("FAIL lh_signed: %h lat %0d want FFFFDEAD lat 3", o_rdata, o_lat); end
        issue(1'b0, 2'b00, 1'b0, 14'h010, 32'd0, 0);
        n_cmp++; if (o_rdata !== 32'hFFFFFFEF) begin
            n_bad++; $display("FAIL lb_lane0: %h want FFFFFFEF", o_rdata); end
        n_cmp++; if (o_wen_cnt !== 0) begin
            n_bad++; $display("FAIL load_nowrite: %0d pulses want 0", o_wen_cnt); end
    endtask

    task automatic test_subword_store;
        issue(1'b1, 2'b00, 1'b0, 14'h011, 32'hFFFFFF55, 0);
        n_cmp++; if (o_lat !== 4) begin n_bad++; $display("FAIL sb_lat: got %0d want 4", o_lat); end
        n_cmp++; if (o_wen_cnt !== 1 || o_wen_cyc !== 3) begin
            n_bad++; $display("FAIL sb_wen: count %0d at %0d want 1 at 3", o_wen_cnt, o_wen_cyc); end
        n_cmp++; if (o_wdata !== 32'hDEAD55EF || o_waddr !== 12'd4) begin
            n_bad++; $display("FAIL sb_merge: %h addr %h want DEAD55EF 4", o_wdata, o_waddr); end
        issue(1'b0, 2'b10, 1'b0, 14'h010, 32'd0, 0);
        n_cmp++; if (o_rdata !== 32'hDEAD55EF || o_lat !== 3) begin
            n_bad++; $display("FAIL sb_readback: %h lat %0d want DEAD55EF lat 3", o_rdata, o_lat); end
        issue(1'b1, 2'b01, 1'b0, 14'h012, 32'h1234A5A5, 0);
        n_cmp++; if (o_wdata !== 32'hA5A555EF || o_wen_cyc !== 3) begin
            n_bad++; $display("FAIL sh_merge: %h at %0d want A5A555EF at 3", o_wdata, o_wen_cyc); end
        issue(1'b0, 2'b01, 1'b1, 14'h012, 32'd0, 0);
        n_cmp++; if (o_rdata !== 32'h0000A5A5) begin
            n_bad++; $display("FAIL lh_unsigned: %h want 0000A5A5", o_rdata); end
        issue(1'b0, 2'b00, 1'b0, 14'h011, 32'd0, 0);
        n_cmp++; if (o_rdata !== 32'h00000055) begin
            n_bad++; $display("FAIL lb_positive: %h want 00000055", o_rdata); end
    endtask

    task automatic test_errors;
        issue(1'b0, 2'b10, 1'b0, 14'h002, 32'd0, 0);
        n_cmp++; if (o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'd0) begin
            n_bad++; $display("FAIL err_word: lat %0d err %b rdata %h want 1 1 0", o_lat, o_err, o_rdata); end
        issue(1'b1, 2'b11, 1'b0, 14'h010, 32'hCAFEF00D, 0);
        n_cmp++; if (o_lat !== 1 || o_err !== 1'b1 || o_wen_cnt !== 0) begin
            n_bad++; $display("FAIL err_size: lat %0d err %b wen %0d want 1 1 0", o_lat, o_err, o_wen_cnt); end
        issue(1'b1, 2'b01, 1'b0, 14'h011, 32'h0000BEEF, 0);
        n_cmp++; if (o_lat !== 1 || o_err !== 1'b1 || o_wen_cnt !== 0) begin
            n_bad++; $display("FAIL err_half: lat %0d err %b wen %0d want 1 1 0", o_lat, o_err, o_wen_cnt); end
        issue(1'b0, 2'b10, 1'b0, 14'h010, 32'd0, 0);
        n_cmp++; if (o_rdata !== 32'hA5A555EF || o_err !== 1'b0) begin
            n_bad++; $display("FAIL err_nowrite: %h err %b want A5A555EF 0", o_rdata, o_err); end
    endtask

    task automatic test_backpressure;
        issue(1'b0, 2'b01, 1'b0, 14'h012, 32'd0, 3);
        n_cmp++; if (o_lat !== 3 || o_rdata !== 32'hFFFFA5A5) begin
            n_bad++; $display("FAIL bp_resp: lat %0d rdata %h want 3 FFFFA5A5", o_lat, o_rdata); end
        n_cmp++; if (o_stable !== 1'b1) begin
            n_bad++; $display("FAIL bp_stable: got %b want 1", o_stable); end
        n_cmp++; if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_ready_after: got %b want 1", req_ready); end
        issue(1'b0, 2'b00, 1'b1, 14'h012, 32'd0, 0);
        n_cmp++; if (o_lat !== 3 || o_rdata !== 32'h000000A5) begin
            n_bad++; $display("FAIL bp_next: lat %0d rdata %h want 3 000000A5", o_lat, o_rdata); end
    endtask

    task automatic test_reset_midop;
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 14'h010; req_wdata = 32'h00000077; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        n_cmp++; if ({req_ready, resp_valid, mem_wEn, resp_err} !== 4'b0) begin
            n_bad++; $display("FAIL rst_mid_ctrl: got %b want 0000", {req_ready, resp_valid, mem_wEn, resp_err}); end
        n_cmp++; if ({resp_rdata, mem_dataIn, mem_addr} !== 76'd0) begin
            n_bad++; $display("FAIL rst_mid_data: rdata=%h dataIn=%h addr=%h want 0", resp_rdata, mem_dataIn, mem_addr); end
        @(posedge clk); #1;
        n_cmp++; if (mem_wEn !== 1'b0 || ram[4] !== 32'hA5A555EF) begin
            n_bad++; $display("FAIL rst_mid_nowrite: wen %b ram %h want 0 A5A555EF", mem_wEn, ram[4]); end
        rst = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 2'b10, 1'b0, 14'h010, 32'd0, 0);
        n_cmp++; if (o_lat !== 3 || o_rdata !== 32'hA5A555EF || o_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_reload: lat %0d rdata %h err %b want 3 A5A555EF 0", o_lat, o_rdata, o_err); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'd0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_word_store;
        test_loads;
        test_subword_store;
        test_errors;
        test_backpressure;
        test_reset_midop;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
